// File: rtl/pool2_controller.sv
// Pooling-stage sequencer: walks IFMs in 2x2 row-pair/column order, issues paired row reads,
// and times fifo/pool enables and next-IFM writes through a 3-stage pipeline.
module pool2_controller #(
  parameter int IFM_SIZE              = 14,
  parameter int IFM_DEPTH             = 3,
  parameter int KERNAL_SIZE           = 2,
  parameter int NUMBER_OF_UNITS       = 3,
  parameter int IFM_SIZE_NEXT         = (IFM_SIZE - KERNAL_SIZE) / 2 + 1,
  parameter int NUM_PASSES            = (IFM_DEPTH + NUMBER_OF_UNITS - 1) / NUMBER_OF_UNITS,
  parameter int ADDRESS_SIZE_IFM      = $clog2(IFM_SIZE * IFM_SIZE),
  parameter int ADDRESS_SIZE_NEXT_IFM = $clog2(IFM_SIZE_NEXT * IFM_SIZE_NEXT),
  parameter int PASS_WIDTH            = (NUM_PASSES > 1) ? $clog2(NUM_PASSES) : 1
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             start,
  output logic                             busy,
  output logic                             done,
  output logic                             rd_en,
  output logic [ADDRESS_SIZE_IFM-1:0]      rd_addr_A,
  output logic [ADDRESS_SIZE_IFM-1:0]      rd_addr_B,
  output logic                             fifo_enable,
  output logic                             pool_enable,
  output logic                             wr_en,
  output logic [ADDRESS_SIZE_NEXT_IFM-1:0] wr_addr,
  output logic [PASS_WIDTH-1:0]            pass_index
);

  localparam int S    = IFM_SIZE_NEXT;
  localparam int ColW = $clog2(2 * S);
  localparam int RowW = (S > 1) ? $clog2(S) : 1;
  localparam int AW   = ADDRESS_SIZE_IFM;

  localparam logic [ColW-1:0]       ColLast  = ColW'(2 * S - 1);
  localparam logic [RowW-1:0]       RowLast  = RowW'(S - 1);
  localparam logic [AW-1:0]         RowLen   = AW'(IFM_SIZE);
  // From the last column of one row pair to column 0 of the next pair (skips an odd tail column)
  localparam logic [AW-1:0]         RowStep  = AW'(1 + IFM_SIZE + (IFM_SIZE - 2 * S));
  localparam logic [PASS_WIDTH-1:0] PassLast = PASS_WIDTH'(NUM_PASSES - 1);

  typedef enum logic [1:0] {StIdle, StRead, StDrain, StDone} state_e;

  state_e                           state_q, state_d;
  logic [ColW-1:0]                  col_q, col_d;
  logic [RowW-1:0]                  row_q, row_d;
  logic [AW-1:0]                    addr_a_q, addr_a_d;
  logic [AW-1:0]                    addr_b_q, addr_b_d;
  logic [1:0]                       drain_q, drain_d;
  logic [PASS_WIDTH-1:0]            pass_q, pass_d;
  logic [ADDRESS_SIZE_NEXT_IFM-1:0] wr_addr_q, wr_addr_d;
  logic                             rd_en_q, busy_q, done_q;
  logic [2:0]                       pipe_en_q, pipe_odd_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= StIdle;
      col_q      <= '0;
      row_q      <= '0;
      addr_a_q   <= '0;
      addr_b_q   <= '0;
      drain_q    <= '0;
      pass_q     <= '0;
      wr_addr_q  <= '0;
      rd_en_q    <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      pipe_en_q  <= '0;
      pipe_odd_q <= '0;
    end else begin
      state_q    <= state_d;
      col_q      <= col_d;
      row_q      <= row_d;
      addr_a_q   <= addr_a_d;
      addr_b_q   <= addr_b_d;
      drain_q    <= drain_d;
      pass_q     <= pass_d;
      wr_addr_q  <= wr_addr_d;
      rd_en_q    <= (state_d == StRead);
      busy_q     <= (state_d != StIdle);
      done_q     <= (state_d == StDone);
      // Stage 0 tracks the read issued this cycle and whether it closes a 2x2 window
      pipe_en_q  <= {pipe_en_q[1:0], rd_en_q};
      pipe_odd_q <= {pipe_odd_q[1:0], col_q[0]};
    end
  end

  always_comb begin
    state_d   = state_q;
    col_d     = col_q;
    row_d     = row_q;
    addr_a_d  = addr_a_q;
    addr_b_d  = addr_b_q;
    drain_d   = drain_q;
    pass_d    = pass_q;
    wr_addr_d = wr_addr_q;

    if (wr_en) begin
      wr_addr_d = wr_addr_q + 1'b1;
    end

    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d   = StRead;
          col_d     = '0;
          row_d     = '0;
          addr_a_d  = '0;
          addr_b_d  = RowLen;
          wr_addr_d = '0;
          pass_d    = '0;
        end
      end
      StRead: begin
        if (col_q == ColLast) begin
          col_d = '0;
          if (row_q == RowLast) begin
            state_d  = StDrain;
            drain_d  = '0;
            addr_a_d = '0;
            addr_b_d = '0;
          end else begin
            row_d    = row_q + 1'b1;
            addr_a_d = addr_a_q + RowStep;
            addr_b_d = addr_b_q + RowStep;
          end
        end else begin
          col_d    = col_q + 1'b1;
          addr_a_d = addr_a_q + 1'b1;
          addr_b_d = addr_b_q + 1'b1;
        end
      end
      StDrain: begin
        if (drain_q == 2'd2) begin
          if (pass_q != PassLast) begin
            // Last write of this pass lands now, so clearing wr_addr cannot overlap passes
            state_d   = StRead;
            pass_d    = pass_q + 1'b1;
            col_d     = '0;
            row_d     = '0;
            addr_a_d  = '0;
            addr_b_d  = RowLen;
            wr_addr_d = '0;
          end else begin
            state_d = StDone;
          end
        end else begin
          drain_d = drain_q + 2'd1;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign rd_en       = rd_en_q;
  assign rd_addr_A   = addr_a_q;
  assign rd_addr_B   = addr_b_q;
  assign fifo_enable = pipe_en_q[0];
  assign pool_enable = pipe_en_q[1] & pipe_odd_q[1];
  assign wr_en       = pipe_en_q[2] & pipe_odd_q[2];
  assign wr_addr     = wr_addr_q;
  assign pass_index  = pass_q;

endmodule

// File: doc/pool2_controller.md
# pool2_controller

Sequencer for the pooling stage: on a `start` pulse it walks the input feature maps (IFMs) in 2x2 row-pair/column order and generates IFM memory read addresses. It drives `fifo_enable` and `pool_enable` for the shared-control bank of `NUMBER_OF_UNITS` pooling units and produces write strobes and addresses for the next-layer IFM memory. It processes `IFM_DEPTH` maps in passes of `NUMBER_OF_UNITS` maps each, then signals `done`.

## Interface

Parameters
- `IFM_SIZE`, 14, IFM width/height in pixels.
- `IFM_DEPTH`, 3, number of input maps.
- `KERNAL_SIZE`, 2, pooling window; fixed at 2, stride 2.
- `NUMBER_OF_UNITS`, 3, parallel pooling units; all share one set of enables.
- `IFM_SIZE_NEXT`, `(IFM_SIZE-KERNAL_SIZE)/2+1`, output map size S.
- `NUM_PASSES`, `(IFM_DEPTH+NUMBER_OF_UNITS-1)/NUMBER_OF_UNITS`.
- `ADDRESS_SIZE_IFM`, `$clog2(IFM_SIZE*IFM_SIZE)`.
- `ADDRESS_SIZE_NEXT_IFM`, `$clog2(IFM_SIZE_NEXT*IFM_SIZE_NEXT)`.
- `PASS_WIDTH`, `max(1,$clog2(NUM_PASSES))`.

Ports
- `clk` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-low.
- `start` in 1: one-cycle request; sampled only in IDLE.
- `busy` out 1: high from the first READ cycle through the DONE cycle.
- `done` out 1: one-cycle pulse at end of all passes.
- `rd_en` out 1: IFM memory read strobe.
- `rd_addr_A` out `ADDRESS_SIZE_IFM`: upper-row pixel address, feeds unit input A.
- `rd_addr_B` out `ADDRESS_SIZE_IFM`: lower-row pixel address, feeds unit input B.
- `fifo_enable` out 1: to all units.
- `pool_enable` out 1: to all units.
- `wr_en` out 1: next-IFM memory write strobe.
- `wr_addr` out `ADDRESS_SIZE_NEXT_IFM`: next-IFM write address.
- `pass_index` out `PASS_WIDTH`: current map group; selects memory banks.

## Operation

- States: IDLE, READ, DRAIN, DONE.
- **IDLE**: all strobes 0. `start`=1 → READ; clear `col`, `row`, `wr_addr`, `pass_index`.
- **READ**: `rd_en`=1 every cycle.
  - `rd_addr_A = row*IFM_SIZE + col`; `rd_addr_B = (row+1)*IFM_SIZE + col`.
  - `col` runs 0..2S-1. At the wrap, `col`←0 and `row`←`row`+2.
  - Rows 0..2S-1 only. For odd `IFM_SIZE`, the last row and column are never addressed.
  - After the read at `row`=2S-2, `col`=2S-1 → DRAIN. Reads per pass = 2S·S.
- **DRAIN**: 3 cycles, no reads; lets the pipeline empty.
  - Then, if `pass_index` < `NUM_PASSES`-1: increment `pass_index`, clear `col`/`row`/`wr_addr`, → READ.
  - Otherwise → DONE.
- **DONE**: `done`=1 for one cycle → IDLE.
- Pipeline, for a read issued at cycle t:
  - `fifo_enable`=1 at t+1 (memory latency 1).
  - `pool_enable`=1 at t+2, only if the read at t had odd `col` (2x2 window complete in the FIFO).
  - `wr_en`=1 at t+3.
  - Implement as a 3-stage shift register of {`rd_en`, `col[0]`}.
- `wr_addr` increments after each `wr_en`. Values run 0..S²-1 per pass, in raster order.
- `start` while busy: ignored. `start` held high: a new run begins in the cycle after DONE returns to IDLE.

## Timing

- Reset (async assert): state IDLE, all outputs 0, counters 0, pipeline cleared. Takes effect immediately, including mid-run; a partial run is abandoned with no `done`.
- Registered outputs throughout; no combinational path from `start` to any output.
- With `start` at cycle 0:
  - READ spans cycles 1..2S²; DRAIN follows for 3 cycles.
  - Each pass lasts 2S²+3 cycles.
  - `done` at cycle 1 + NUM_PASSES·(2S²+3).
- Pass boundary: the last `wr_en` of pass p occurs in the final DRAIN cycle. The first read of pass p+1 follows in the next cycle. Writes never overlap across passes; `pass_index` is stable for all reads and writes of its pass.

## Test plan

- Defaults, `start` at cycle 0:
  - `rd_en` on cycles 1–98; first reads (A,B)=(0,14),(1,15).
  - 49 `wr_en` pulses, `wr_addr` 0..48, first on cycle 5, last on cycle 101.
  - `pool_enable` on cycles 4,6,…; `done` only on cycle 102.
- `IFM_SIZE`=5 (S=2):
  - 8 reads; second row pair starts at (A,B)=(10,15).
  - Addresses 4, 9, 14, 19 and 20–24 never appear.
  - 4 writes; `done` at cycle 12.
- `IFM_DEPTH`=5, `NUMBER_OF_UNITS`=2 with default size:
  - 3 passes; `pass_index` 0→1→2.
  - `wr_addr` restarts at 0 each pass; 147 writes total.
  - Exactly one `done`, at cycle 304.
- `start` pulsed at cycles 0, 20 and 102: second pulse ignored; a single run completes, with `done` at 102 and no further reads. `start` asserted at cycle 103 begins a new run whose READ starts at cycle 104.
- `reset` low at cycle 40 for 2 cycles:
  - All outputs 0 within cycle 40; no `done`.
  - After release, `start` yields a full clean run starting at (0,14) and `wr_addr` 0.
